// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter: one-hot grant plus address/data-phase owner indices.
// Define AHB_LOCK_EN to build master lock support (ahb_lock_in / ahb_mastlock_out).
module ahb_bus_arbiter #(
  parameter int AHB_MASTER_NUM     = 4,
  parameter int AHB_DEFAULT_MASTER = 0,
  parameter int AHB_MAX_HOLD       = 16,
  localparam int MW = $clog2(AHB_MASTER_NUM)
) (
  input  logic                      ahb_clk_in,
  input  logic                      ahb_rst_in,
  input  logic [AHB_MASTER_NUM-1:0] ahb_busreq_in,
  input  logic [1:0]                ahb_trans_in,
  input  logic [2:0]                ahb_burst_in,
  input  logic                      ahb_ready_in,
  output logic [AHB_MASTER_NUM-1:0] ahb_grant_out,
  output logic [MW-1:0]             ahb_master_out,
  output logic [MW-1:0]             ahb_master_data_out
`ifdef AHB_LOCK_EN
  ,
  input  logic [AHB_MASTER_NUM-1:0] ahb_lock_in,
  output logic                      ahb_mastlock_out
`endif
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [2:0] HB_SINGLE = 3'b000;
  localparam logic [2:0] HB_INCR   = 3'b001;
  localparam logic [MW-1:0] DEF_IDX = MW'(AHB_DEFAULT_MASTER);
  localparam logic [AHB_MASTER_NUM-1:0] ONE_HOT_LSB = {{(AHB_MASTER_NUM-1){1'b0}}, 1'b1};
  localparam logic [7:0] HOLD_LAST = 8'(AHB_MAX_HOLD - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_BURST} state_t;

  state_t                    r_state;
  state_t                    w_nextState;
  logic [AHB_MASTER_NUM-1:0] r_grant;
  logic [MW-1:0]             r_owner;
  logic [MW-1:0]             r_dataOwner;
  logic [MW-1:0]             r_lastOwner;
  logic [3:0]                r_beatCnt;
  logic [7:0]                r_holdCnt;
  logic                      r_isIncr;

  logic          w_isIdle;
  logic          w_isNonseq;
  logic          w_isSeq;
  logic          w_burstXfer;
  logic          w_finalBeat;
  logic          w_forceRel;
  logic          w_arbPoint;
  logic          w_lockHold;
  logic          w_found;
  logic [MW-1:0] w_winner;
  logic [MW-1:0] w_idx;
  logic [MW-1:0] w_nextOwner;
  logic [MW-1:0] w_nextLast;
  logic          w_startBurst;
  logic          w_restartHold;
  logic [3:0]    w_beatLoad;

  assign w_isIdle    = (ahb_trans_in == HT_IDLE);
  assign w_isNonseq  = (ahb_trans_in == HT_NONSEQ);
  assign w_isSeq     = (ahb_trans_in == HT_SEQ);
  assign w_burstXfer = w_isNonseq && (ahb_burst_in != HB_SINGLE);
  assign w_finalBeat = (r_state == ST_BURST) && w_isSeq && !r_isIncr && (r_beatCnt == 4'd1);
  assign w_forceRel  = (r_state == ST_BURST) && w_isSeq && r_isIncr && (r_holdCnt == HOLD_LAST);
  assign w_arbPoint  = ahb_ready_in &&
                       ((r_state == ST_IDLE) ||
                        ((r_state == ST_OWN) && (w_isIdle || (w_isNonseq && !w_burstXfer))) ||
                        ((r_state == ST_BURST) && (w_isIdle || w_isNonseq)) ||
                        w_finalBeat || w_forceRel);

`ifdef AHB_LOCK_EN
  assign w_lockHold = ahb_lock_in[r_owner];
`else
  assign w_lockHold = 1'b0;
`endif

  always_comb begin
    unique case (ahb_burst_in[2:1])
      2'b01:   w_beatLoad = 4'd3;
      2'b10:   w_beatLoad = 4'd7;
      2'b11:   w_beatLoad = 4'd15;
      default: w_beatLoad = 4'd0;
    endcase
  end

  // Round-robin search starts just after the last winner and wraps back to it.
  always_comb begin
    w_found  = 1'b0;
    w_winner = DEF_IDX;
    w_idx    = '0;
    for (int i = 1; i <= AHB_MASTER_NUM; i++) begin
      w_idx = MW'((int'(r_lastOwner) + i) % AHB_MASTER_NUM);
      if (!w_found && ahb_busreq_in[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in)
      r_state <= ST_IDLE;
    else if (ahb_ready_in)
      r_state <= w_nextState;
  end

  // A retained owner that starts a new burst, or is released from an INCR hold, stays in ST_BURST.
  always_comb begin
    w_nextState   = r_state;
    w_nextOwner   = r_owner;
    w_nextLast    = r_lastOwner;
    w_startBurst  = 1'b0;
    w_restartHold = 1'b0;
    if (w_arbPoint) begin
      if (w_lockHold || w_found) begin
        if (!w_lockHold) begin
          w_nextOwner = w_winner;
          w_nextLast  = w_winner;
        end
        if ((w_nextOwner == r_owner) && w_burstXfer) begin
          w_nextState  = ST_BURST;
          w_startBurst = 1'b1;
        end else if ((w_nextOwner == r_owner) && w_forceRel) begin
          w_nextState   = ST_BURST;
          w_restartHold = 1'b1;
        end else begin
          w_nextState = ST_OWN;
        end
      end else begin
        w_nextOwner = DEF_IDX;
        w_nextState = ST_IDLE;
      end
    end else if (ahb_ready_in && (r_state == ST_OWN) && w_burstXfer) begin
      w_nextState  = ST_BURST;
      w_startBurst = 1'b1;
    end
  end

  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      r_grant     <= ONE_HOT_LSB << AHB_DEFAULT_MASTER;
      r_owner     <= DEF_IDX;
      r_dataOwner <= DEF_IDX;
      r_lastOwner <= DEF_IDX;
      r_beatCnt   <= 4'd0;
      r_holdCnt   <= 8'd0;
      r_isIncr    <= 1'b0;
    end else if (ahb_ready_in) begin
      r_grant     <= ONE_HOT_LSB << w_nextOwner;
      r_owner     <= w_nextOwner;
      r_dataOwner <= r_owner;
      r_lastOwner <= w_nextLast;
      if (w_startBurst) begin
        r_isIncr <= (ahb_burst_in == HB_INCR);
        if (ahb_burst_in == HB_INCR)
          r_holdCnt <= 8'd0;
        else
          r_beatCnt <= w_beatLoad;
      end else if (w_restartHold) begin
        r_holdCnt <= 8'd0;
      end else if ((r_state == ST_BURST) && w_isSeq) begin
        if (r_isIncr)
          r_holdCnt <= r_holdCnt + 8'd1;
        else
          r_beatCnt <= r_beatCnt - 4'd1;
      end
    end
  end

`ifdef AHB_LOCK_EN
  logic r_mastLock;

  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in)
      r_mastLock <= 1'b0;
    else if (ahb_ready_in)
      r_mastLock <= ahb_lock_in[w_nextOwner];
  end
`endif

  always_comb begin
    ahb_grant_out       = r_grant;
    ahb_master_out      = r_owner;
    ahb_master_data_out = r_dataOwner;
`ifdef AHB_LOCK_EN
    ahb_mastlock_out    = r_mastLock;
`endif
  end

endmodule
